scurve_scan_ctrl: RTL and testbench

Threshold-scan sequencer for S-curve measurement, downstream of the single-input S-curve counter (`Test_Start`/`CPT_MAX` → `CPT_PULSE`/`CPT_TRIGGER`/`CPT_DONE`).
- For each DAC code in a programmed range it:
  - loads the threshold DAC and waits for it to settle;
  - runs one counter measurement and captures the pulse and trigger counts;
  - pushes a 3-word record into the readout FIFO.
- Ends every scan with a trailer word.

---
 rtl/scurve_scan_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_scurve_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scurve_scan_ctrl.sv
// Threshold-scan sequencer for S-curve measurement: steps the threshold DAC over
// a programmed range, runs one counter measurement per code and streams records to a FIFO.
`default_nettype none

module scurve_scan_ctrl #(
  parameter int DAC_WIDTH     = 10,
  parameter int SETTLE_CYCLES = 400
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 scan_start,
  input  logic                 scan_abort,
  input  logic [DAC_WIDTH-1:0] dac_start,
  input  logic [DAC_WIDTH-1:0] dac_stop,
  input  logic [DAC_WIDTH-1:0] dac_step,
  input  logic [15:0]          cpt_max_in,
  output logic [DAC_WIDTH-1:0] dac_code,
  output logic                 dac_load,
  input  logic                 dac_ack,
  output logic                 test_start,
  output logic [15:0]          cpt_max,
  input  logic [15:0]          cpt_pulse,
  input  logic [15:0]          cpt_trigger,
  input  logic                 cpt_done,
  output logic [15:0]          fifo_data,
  output logic                 fifo_wr_en,
  input  logic                 fifo_full,
  output logic                 scan_busy,
  output logic                 scan_done
);

  // state      | meaning
  // IDLE       | waiting for scan_start
  // LOAD_DAC   | one-cycle DAC write strobe
  // WAIT_ACK   | waiting for DAC write completion
  // SETTLE     | threshold settling delay
  // COUNT      | counter enabled, waiting for cpt_done
  // WR_HDR     | write header {101010, dac_code}
  // WR_PULSE   | write latched pulse count
  // WR_TRIG    | write latched trigger count
  // NEXT       | advance code or finish
  // WR_TRAILER | write 16'hFFFF
  // DONE       | one-cycle scan_done pulse
  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] LOAD_DAC   = 4'd1;
  localparam logic [3:0] WAIT_ACK   = 4'd2;
  localparam logic [3:0] SETTLE     = 4'd3;
  localparam logic [3:0] COUNT      = 4'd4;
  localparam logic [3:0] WR_HDR     = 4'd5;
  localparam logic [3:0] WR_PULSE   = 4'd6;
  localparam logic [3:0] WR_TRIG    = 4'd7;
  localparam logic [3:0] NEXT       = 4'd8;
  localparam logic [3:0] WR_TRAILER = 4'd9;
  localparam logic [3:0] DONE       = 4'd10;

  localparam int             CW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]  SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [15:0]    HDR_TAG     = 16'hA800;
  localparam logic [15:0]    TRAILER     = 16'hFFFF;

  logic [3:0]           state_q,    state_d;
  logic [DAC_WIDTH-1:0] dac_code_q, dac_code_d;
  logic [DAC_WIDTH-1:0] stop_q,     stop_d;
  logic [DAC_WIDTH-1:0] step_q,     step_d;
  logic [15:0]          cpt_max_q,  cpt_max_d;
  logic [15:0]          pulse_q,    pulse_d;
  logic [15:0]          trig_q,     trig_d;
  logic [CW-1:0]        settle_q,   settle_d;
  logic [DAC_WIDTH:0]   nxt;
  logic                 wr_state;

  // Extra bit keeps the range-end compare correct at the top of the DAC range.
  assign nxt = {1'b0, dac_code_q} + {1'b0, step_q};

  always_comb begin
    state_d    = state_q;
    dac_code_d = dac_code_q;
    stop_d     = stop_q;
    step_d     = step_q;
    cpt_max_d  = cpt_max_q;
    pulse_d    = pulse_q;
    trig_d     = trig_q;
    settle_d   = settle_q;
    case (state_q)
      IDLE: begin
        if (scan_start) begin
          stop_d    = dac_stop;
          step_d    = (dac_step == '0) ? DAC_WIDTH'(1) : dac_step;
          cpt_max_d = cpt_max_in;
          if (dac_start > dac_stop) begin
            state_d = WR_TRAILER;
          end else begin
            dac_code_d = dac_start;
            state_d    = LOAD_DAC;
          end
        end
      end
      LOAD_DAC: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (dac_ack) begin
          settle_d = SETTLE_LOAD;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == '0) state_d = COUNT;
        else                settle_d = settle_q - 1'b1;
      end
      COUNT: begin
        if (cpt_done) begin
          pulse_d = cpt_pulse;
          trig_d  = cpt_trigger;
          state_d = WR_HDR;
        end
      end
      WR_HDR:     if (!fifo_full) state_d = WR_PULSE;
      WR_PULSE:   if (!fifo_full) state_d = WR_TRIG;
      WR_TRIG:    if (!fifo_full) state_d = NEXT;
      NEXT: begin
        if (nxt > {1'b0, stop_q}) begin
          state_d = WR_TRAILER;
        end else begin
          dac_code_d = nxt[DAC_WIDTH-1:0];
          state_d    = LOAD_DAC;
        end
      end
      WR_TRAILER: if (!fifo_full) state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    if (scan_abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      dac_code_q <= '0;
      stop_q     <= '0;
      step_q     <= '0;
      cpt_max_q  <= '0;
      pulse_q    <= '0;
      trig_q     <= '0;
      settle_q   <= '0;
    end else begin
      state_q    <= state_d;
      dac_code_q <= dac_code_d;
      stop_q     <= stop_d;
      step_q     <= step_d;
      cpt_max_q  <= cpt_max_d;
      pulse_q    <= pulse_d;
      trig_q     <= trig_d;
      settle_q   <= settle_d;
    end
  end

  assign wr_state = (state_q == WR_HDR) || (state_q == WR_PULSE) ||
                    (state_q == WR_TRIG) || (state_q == WR_TRAILER);

  // Data is a pure function of state and latched values, so it holds while full.
  always_comb begin
    fifo_data = '0;
    case (state_q)
      WR_HDR:     fifo_data = HDR_TAG | 16'(dac_code_q);
      WR_PULSE:   fifo_data = pulse_q;
      WR_TRIG:    fifo_data = trig_q;
      WR_TRAILER: fifo_data = TRAILER;
      default:    fifo_data = '0;
    endcase
  end

  assign fifo_wr_en = wr_state && !fifo_full;
  assign dac_code   = dac_code_q;
  assign dac_load   = (state_q == LOAD_DAC);
  assign test_start = (state_q == COUNT);
  assign cpt_max    = cpt_max_q;
  assign scan_busy  = (state_q != IDLE);
  assign scan_done  = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_scurve_scan_ctrl.sv
// Self-checking bench for scurve_scan_ctrl: vector table of scan ranges with a word
// scoreboard, plus hand sequences for backpressure, abort and reset mid-scan.
`timescale 1ns/1ps

module tb_scurve_scan_ctrl;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          scan_start = 1'b0, scan_abort = 1'b0;
  logic [DW-1:0] dac_start = '0, dac_stop = '0, dac_step = '0;
  logic [15:0]   cpt_max_in = '0;
  logic [DW-1:0] dac_code;
  logic          dac_load;
  logic          dac_ack = 1'b0;
  logic          test_start;
  logic [15:0]   cpt_max;
  logic [15:0]   cpt_pulse = '0, cpt_trigger = '0;
  logic          cpt_done = 1'b0;
  logic [15:0]   fifo_data;
  logic          fifo_wr_en;
  logic          fifo_full = 1'b0;
  logic          scan_busy, scan_done;

  scurve_scan_ctrl #(.DAC_WIDTH(DW), .SETTLE_CYCLES(400)) dut (
    .clk(clk), .reset_n(reset_n), .scan_start(scan_start), .scan_abort(scan_abort),
    .dac_start(dac_start), .dac_stop(dac_stop), .dac_step(dac_step), .cpt_max_in(cpt_max_in),
    .dac_code(dac_code), .dac_load(dac_load), .dac_ack(dac_ack), .test_start(test_start),
    .cpt_max(cpt_max), .cpt_pulse(cpt_pulse), .cpt_trigger(cpt_trigger), .cpt_done(cpt_done),
    .fifo_data(fifo_data), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
    .scan_busy(scan_busy), .scan_done(scan_done)
  );

  always #12.5 clk = ~clk;

  // DAC acknowledges one cycle after the load strobe.
  always @(posedge clk) dac_ack <= dac_load;

  // Counter model: finishes a few cycles after enable, clears while enable is low.
  int cnt = 0;
  always @(posedge clk) begin
    if (!test_start) begin
      cnt      <= 0;
      cpt_done <= 1'b0;
    end else begin
      cnt <= cnt + 1;
      if (cnt == 5) cpt_done <= 1'b1;
    end
  end

  typedef struct {
    int start; int stop; int step; int cmax; int pulse; int trig;
    int loads; int words;
  } vec_t;
  vec_t vecs[6];

  int          n_vec = 0, n_err = 0;
  logic [15:0] exp_q[$];
  int          dacq[$];
  int          load_cnt, done_cnt, word_cnt, ts_cnt, cur_cmax;
  logic        bp_chk = 1'b0;
  logic [15:0] bp_word;
  logic        last_wr;
  logic [15:0] last_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got 0x%0h, expected nothing at %0t", name, act, $time);
  endtask

  task automatic monitor();
    last_wr = fifo_wr_en;
    if (fifo_wr_en) begin
      word_cnt++;
      last_data = fifo_data;
      chk("wr_while_full", 32'(fifo_full), 0);
      if (exp_q.size() == 0) flag("unexpected_word", 32'(fifo_data));
      else chk("fifo_word", 32'(fifo_data), 32'(exp_q.pop_front()));
    end
    if (dac_load) begin
      load_cnt++;
      if (dacq.size() == 0) flag("unexpected_load", 32'(dac_code));
      else chk("dac_code", 32'(dac_code), dacq.pop_front());
    end
    if (bp_chk) begin
      chk("bp_wr_en", 32'(fifo_wr_en), 0);
      chk("bp_data", 32'(fifo_data), 32'(bp_word));
    end
    if (test_start) begin
      ts_cnt++;
      chk("cpt_max", 32'(cpt_max), cur_cmax);
    end
    if (scan_done) done_cnt++;
  endtask

  // Inputs are changed at the falling edge, then the cycle is sampled before the rising edge.
  task automatic tick();
    #1;
    monitor();
    @(negedge clk);
  endtask

  task automatic clear();
    exp_q.delete();
    dacq.delete();
    load_cnt = 0; done_cnt = 0; word_cnt = 0; ts_cnt = 0;
    last_wr = 1'b0; last_data = '0;
  endtask

  task automatic push_model(input vec_t v);
    int st;
    st = (v.step == 0) ? 1 : v.step;
    for (int c = v.start; c <= v.stop; c += st) begin
      dacq.push_back(c);
      exp_q.push_back(16'hA800 | c[15:0]);
      exp_q.push_back(v.pulse[15:0]);
      exp_q.push_back(v.trig[15:0]);
    end
    exp_q.push_back(16'hFFFF);
  endtask

  task automatic start_scan(input vec_t v);
    dac_start   = v.start[DW-1:0];
    dac_stop    = v.stop[DW-1:0];
    dac_step    = v.step[DW-1:0];
    cpt_max_in  = v.cmax[15:0];
    cpt_pulse   = v.pulse[15:0];
    cpt_trigger = v.trig[15:0];
    cur_cmax    = v.cmax & 32'hFFFF;
    scan_start  = 1'b1;
    tick();
    scan_start  = 1'b0;
    dac_start = '0; dac_stop = '0; dac_step = '0; cpt_max_in = '0;
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (done_cnt == 0 && i < 6000) begin
      tick();
      i++;
    end
    if (done_cnt == 0) flag("scan_done_timeout", 32'(i));
    tick();
    chk("busy_after_done", 32'(scan_busy), 0);
    repeat (5) tick();
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    clear();
    push_model(v);
    start_scan(v);
    wait_done();
    chk({tag, "_loads"}, load_cnt, v.loads);
    chk({tag, "_words"}, word_cnt, v.words);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_words_left"}, exp_q.size(), 0);
    chk({tag, "_ts_seen"}, 32'(ts_cnt > 0), 32'(v.loads > 0));
  endtask

  initial begin
    int i;
    vecs[0] = '{100,  120,  10, 1000,  1000,  500,   3, 10};
    vecs[1] = '{200,  100,  5,  77,    1,     2,     0, 1};
    vecs[2] = '{1016, 1023, 8,  50,    50,    25,    1, 4};
    vecs[3] = '{5,    5,    0,  10,    9,     8,     1, 4};
    vecs[4] = '{0,    3,    0,  3,     3,     0,     4, 13};
    vecs[5] = '{1020, 1023, 1,  65535, 65535, 12345, 4, 13};
    clear();

    #100;
    chk("rst_dac_code", 32'(dac_code), 0);
    chk("rst_fifo_data", 32'(fifo_data), 0);
    chk("rst_test_start", 32'(test_start), 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("rst_cpt_max", 32'(cpt_max), 0);
    chk("rst_busy", 32'(scan_busy), 0);
    chk("rst_wr_en", 32'(fifo_wr_en), 0);
    chk("rst_dac_load", 32'(dac_load), 0);
    chk("rst_done", 32'(scan_done), 0);

    for (int k = 0; k < 6; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Backpressure during WR_PULSE of the first step.
    clear();
    push_model(vecs[0]);
    start_scan(vecs[0]);
    i = 0;
    while (!(last_wr && last_data == 16'hA864) && i < 2000) begin
      tick();
      i++;
    end
    if (i >= 2000) flag("bp_header_timeout", 32'(i));
    fifo_full = 1'b1;
    bp_word   = 16'h03E8;
    bp_chk    = 1'b1;
    repeat (20) tick();
    bp_chk    = 1'b0;
    fifo_full = 1'b0;
    wait_done();
    chk("bp_words", word_cnt, 10);
    chk("bp_words_left", exp_q.size(), 0);
    chk("bp_done_pulses", done_cnt, 1);

    // Abort in mid-COUNT: no words, no trailer, no scan_done.
    clear();
    dacq.push_back(100);
    start_scan(vecs[0]);
    i = 0;
    while (!test_start && i < 2000) begin
      tick();
      i++;
    end
    if (i >= 2000) flag("abort_count_timeout", 32'(i));
    tick();
    tick();
    scan_abort = 1'b1;
    tick();
    scan_abort = 1'b0;
    chk("abort_test_start", 32'(test_start), 0);
    chk("abort_busy", 32'(scan_busy), 0);
    repeat (30) tick();
    chk("abort_words", word_cnt, 0);
    chk("abort_done", done_cnt, 0);
    chk("abort_loads", load_cnt, 1);
    run_vec(vecs[2], "post_abort");

    // Reset during SETTLE of the first step.
    clear();
    dacq.push_back(100);
    start_scan(vecs[0]);
    repeat (12) tick();
    reset_n = 1'b0;
    tick();
    chk("midrst_busy", 32'(scan_busy), 0);
    chk("midrst_dac_code", 32'(dac_code), 0);
    reset_n = 1'b1;
    repeat (500) tick();
    chk("midrst_words", word_cnt, 0);
    chk("midrst_ts", ts_cnt, 0);
    run_vec(vecs[0], "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
